uart_rx_oversampler: RTL

Serial receiver for the controller's UART link and the receive-side counterpart of the voted `tx` line driven by the triple-redundant control modules. It runs in the same `clk` domain, uses the same 16-bit `preescalar_data_rate` value, and oversamples `rx` 8× per bit. Each bit is decided by a 2-of-3 majority vote of its mid-bit samples. It emits one-cycle pulses carrying received characters and error flags to downstream command logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tick_gen.sv | 33 +++
 rtl/uart_rx_oversampler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the majority vote used to decide each bit from its mid-bit samples.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 8;

   localparam logic [2:0] SC_VOTE_A = 3'd3;
   localparam logic [2:0] SC_VOTE_B = 3'd4;
   localparam logic [2:0] SC_VOTE_C = 3'd5;
   localparam logic [2:0] SC_LAST   = 3'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick generator: one-cycle tick every preescalar_data_rate clocks,
// with a prescaler of 0 behaving as 1. Shared with the transmitter.
module uart_tick_gen #(
   parameter int unsigned PRESCALER_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PRESCALER_WIDTH-1:0] preescalar_data_rate,
   output logic                       tick
);

   logic [PRESCALER_WIDTH-1:0] count;
   logic [PRESCALER_WIDTH-1:0] reload;

   // The prescaler is only sampled at reload, so changes apply from the next period.
   always_comb begin
      reload = '0;
      if (preescalar_data_rate != '0)
         reload = preescalar_data_rate - 1'b1;
   end

   always_comb tick = (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (tick)
         count <= reload;
      else
         count <= count - 1'b1;
   end

endmodule

// File: rtl/uart_rx_oversampler.sv
// 8x oversampling UART receiver with 2-of-3 mid-bit voting, framing/noise flags.
// Optional even parity check when UART_RX_PARITY_EN is defined.
module uart_rx_oversampler
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned PRESCALER_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx,
   input  logic [PRESCALER_WIDTH-1:0] preescalar_data_rate,
   output logic [DATA_WIDTH-1:0]      rx_data,
   output logic                       rx_valid,
   output logic                       frame_error,
   output logic                       noise_detected,
   output logic                       rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                       parity_error
`endif
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic rx_meta, rx_sync, tick;

   rx_state_t             state, state_n;
   logic [2:0]            sc, sc_n;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
   logic [DATA_WIDTH-1:0] shift_q, shift_n, rx_data_n;
   logic                  samp_a, samp_a_n, samp_b, samp_b_n;
   logic                  noise_q, noise_n, frame_noise;
   logic                  vote, noisy;
   logic                  rx_valid_n, frame_error_n, noise_detected_n;
`ifdef UART_RX_PARITY_EN
   logic                  par_q, par_n, parity_error_n;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   uart_tick_gen #(.PRESCALER_WIDTH(PRESCALER_WIDTH)) u_tick (
      .clk                  (clk),
      .rst                  (rst),
      .preescalar_data_rate (preescalar_data_rate),
      .tick                 (tick)
   );

   // Samples at sc=3/4 are held; the sc=5 sample is the live synchronized line.
   always_comb begin
      vote        = maj3(samp_a, samp_b, rx_sync);
      noisy       = (samp_a != rx_sync) || (samp_b != rx_sync);
      frame_noise = noise_q | noisy;
   end

   always_comb begin
      state_n          = state;
      sc_n             = sc;
      bit_cnt_n        = bit_cnt;
      shift_n          = shift_q;
      samp_a_n         = samp_a;
      samp_b_n         = samp_b;
      noise_n          = noise_q;
      rx_data_n        = rx_data;
      rx_valid_n       = 1'b0;
      frame_error_n    = 1'b0;
      noise_detected_n = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n            = par_q;
      parity_error_n   = 1'b0;
`endif
      if (tick) begin
         if (state != ST_IDLE && state != ST_BREAK) begin
            sc_n = sc + 3'd1;
            if (sc == SC_VOTE_A) samp_a_n = rx_sync;
            if (sc == SC_VOTE_B) samp_b_n = rx_sync;
            if (sc == SC_VOTE_C) noise_n  = frame_noise;
         end
         case (state)
            ST_IDLE: begin
               if (!rx_sync) begin
                  state_n   = ST_START;
                  sc_n      = '0;
                  bit_cnt_n = '0;
                  noise_n   = 1'b0;
               end
            end
            ST_START: begin
               if (sc == SC_VOTE_C && vote)
                  state_n = ST_IDLE;
               else if (sc == SC_LAST)
                  state_n = ST_DATA;
            end
            ST_DATA: begin
               if (sc == SC_VOTE_C) begin
                  shift_n = shift_q >> 1;
                  shift_n[DATA_WIDTH-1] = vote;
               end
               if (sc == SC_LAST) begin
                  bit_cnt_n = bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                     state_n = ST_PARITY;
`else
                     state_n = ST_STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sc == SC_VOTE_C) par_n = vote;
               if (sc == SC_LAST) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
               if (sc == SC_VOTE_C) begin
                  noise_detected_n = frame_noise;
                  if (vote) begin
                     rx_data_n  = shift_q;
                     rx_valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_error_n = par_q ^ (^shift_q);
`endif
                     state_n    = ST_IDLE;
                  end else begin
                     frame_error_n = 1'b1;
                     state_n       = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_sync) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb rx_busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         sc             <= '0;
         bit_cnt        <= '0;
         shift_q        <= '0;
         samp_a         <= 1'b1;
         samp_b         <= 1'b1;
         noise_q        <= 1'b0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         frame_error    <= 1'b0;
         noise_detected <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q          <= 1'b0;
         parity_error   <= 1'b0;
`endif
      end else begin
         state          <= state_n;
         sc             <= sc_n;
         bit_cnt        <= bit_cnt_n;
         shift_q        <= shift_n;
         samp_a         <= samp_a_n;
         samp_b         <= samp_b_n;
         noise_q        <= noise_n;
         rx_data        <= rx_data_n;
         rx_valid       <= rx_valid_n;
         frame_error    <= frame_error_n;
         noise_detected <= noise_detected_n;
`ifdef UART_RX_PARITY_EN
         par_q          <= par_n;
         parity_error   <= parity_error_n;
`endif
      end
   end

endmodule
